// File: rtl/fifo_uart_pkg.sv
// Shared types for the FIFO-fed UART transmitter: FSM states, parity modes, frame sizing.
// Pure declarations; no timing or flow-control behaviour lives here.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_tx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Serial bits in one frame: start + data + optional parity + stop bits.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input logic        parity_en,
                                               input logic        two_stop);
        return 1 + data_bits + (parity_en ? 1 : 0) + (two_stop ? 2 : 1);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: o_tick marks the last cycle of each (div+1)-cycle bit, reloading itself.
// Divisor is captured on i_load and held until the next load; no backpressure.
module uart_bit_timer #(
    parameter int G_DIVWIDTH = 16
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  i_load,
    input  logic [G_DIVWIDTH-1:0] i_div,
    input  logic                  i_run,
    output logic                  o_tick
);

    localparam logic [G_DIVWIDTH-1:0] CNT_ONE = G_DIVWIDTH'(1);

    logic [G_DIVWIDTH-1:0] r_div;
    logic [G_DIVWIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_div <= i_div;
            r_cnt <= i_div;
        end else if (i_run) begin
            if (r_cnt == '0) begin
                r_cnt <= r_div;
            end else begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    assign o_tick = i_run && (r_cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a standard-read FIFO and serialises them as UART frames; txd falls 2 cycles after the pop.
// Pops only when idle, enabled and non-empty (never during reset); each frame runs to completion once started.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int G_DATAWIDTH = 8,
    parameter int G_DIVWIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   i_enable,
    input  logic [G_DIVWIDTH-1:0]  i_clkdiv,
    input  logic                   i_parity_en,
    input  logic                   i_parity_odd,
    input  logic                   i_two_stop,
    input  logic                   i_fifo_empty,
    output logic                   o_fifo_rd_en,
    input  logic [G_DATAWIDTH-1:0] i_fifo_dout,
    output logic                   o_txd,
    output logic                   o_busy,
    output logic                   o_frame_done
);

    localparam int CW = (G_DATAWIDTH > 1) ? $clog2(G_DATAWIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(G_DATAWIDTH - 1);
    localparam logic [CW-1:0] BIT_ONE  = CW'(1);

    uart_tx_state_e         r_state;
    logic [G_DATAWIDTH-1:0] r_shift;
    logic [CW-1:0]          r_bitcnt;
    logic                   r_stopcnt;
    logic                   r_par_en;
    logic                   r_two_stop;
    logic                   r_par_bit;
    logic                   r_txd;
    logic                   r_frame_done;

    uart_tx_state_e         w_state_nxt;
    logic [G_DATAWIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]          w_bitcnt_nxt;
    logic                   w_stopcnt_nxt;
    logic                   w_txd_nxt;
    logic                   w_timer_load;
    logic                   w_timer_run;
    logic                   w_tick;
    logic                   w_rd_en;

    // Gating with srst makes a simultaneous reset and pop resolve in favour of reset.
    assign w_rd_en     = (r_state == ST_IDLE) && i_enable && !i_fifo_empty && !srst;
    assign w_timer_run = (r_state == ST_START) || (r_state == ST_DATA) ||
                         (r_state == ST_PARITY) || (r_state == ST_STOP);

    uart_bit_timer #(
        .G_DIVWIDTH (G_DIVWIDTH)
    ) u_bit_timer (
        .clk    (clk),
        .srst   (srst),
        .i_load (w_timer_load),
        .i_div  (i_clkdiv),
        .i_run  (w_timer_run),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bitcnt_nxt  = r_bitcnt;
        w_stopcnt_nxt = r_stopcnt;
        w_timer_load  = 1'b0;
        w_txd_nxt     = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_rd_en) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_shift_nxt   = i_fifo_dout;
                w_bitcnt_nxt  = '0;
                w_stopcnt_nxt = 1'b0;
                w_timer_load  = 1'b1;
                w_state_nxt   = ST_START;
            end
            ST_START: begin
                if (w_tick) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bitcnt == LAST_BIT) begin
                        w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + BIT_ONE;
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_two_stop && !r_stopcnt) begin
                        w_stopcnt_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Line level is derived from the next state so o_txd can be a plain register.
        case (w_state_nxt)
            ST_START:  w_txd_nxt = 1'b0;
            ST_DATA:   w_txd_nxt = w_shift_nxt[0];
            ST_PARITY: w_txd_nxt = r_par_bit;
            default:   w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_stopcnt    <= 1'b0;
            r_par_en     <= 1'b0;
            r_two_stop   <= 1'b0;
            r_par_bit    <= 1'b0;
            r_txd        <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_stopcnt    <= w_stopcnt_nxt;
            r_txd        <= w_txd_nxt;
            r_frame_done <= (r_state == ST_STOP) && (w_state_nxt == ST_IDLE);
            if (r_state == ST_FETCH) begin
                r_par_en   <= i_parity_en;
                r_two_stop <= i_two_stop;
                r_par_bit  <= (^i_fifo_dout) ^ (i_parity_odd == PARITY_ODD);
            end
        end
    end

    assign o_fifo_rd_en = w_rd_en;
    assign o_txd        = r_txd;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small standard-read FIFO model feeding the DUT.
// Frames are captured bit by bit off o_txd and compared with hand-computed bit patterns.
module tb_fifo_uart_tx;

    logic        clk = 1'b0;
    logic        srst;
    logic        i_enable;
    logic [15:0] i_clkdiv;
    logic        i_parity_en;
    logic        i_parity_odd;
    logic        i_two_stop;
    logic        fifo_empty;
    logic        rd_en;
    logic [7:0]  fifo_dout = 8'h00;
    logic        txd;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .G_DATAWIDTH (8),
        .G_DIVWIDTH  (16)
    ) dut (
        .clk          (clk),
        .srst         (srst),
        .i_enable     (i_enable),
        .i_clkdiv     (i_clkdiv),
        .i_parity_en  (i_parity_en),
        .i_parity_odd (i_parity_odd),
        .i_two_stop   (i_two_stop),
        .i_fifo_empty (fifo_empty),
        .o_fifo_rd_en (rd_en),
        .i_fifo_dout  (fifo_dout),
        .o_txd        (txd),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    // Standard-read FIFO: dout updates the cycle after rd_en.
    logic [7:0] mem [16];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rd_en) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 4'd1;
        end
    end

    int cyc = 0;
    int rd_cnt = 0;
    int fd_cnt = 0;
    int last_rd_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        if (rd_en === 1'b1) begin
            rd_cnt = rd_cnt + 1;
            last_rd_cyc = cyc;
        end
        if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    // Waits (bounded) for a start bit, then samples every cycle of nbits bits.
    task automatic rx_frame(input int div, input int nbits, output logic [15:0] bits,
                            output int glitches, output int start_cyc, output int end_cyc);
        int t;
        t = 0;
        bits = '0;
        glitches = 0;
        start_cyc = 0;
        end_cyc = 0;
        @(negedge clk);
        while (txd !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (txd !== 1'b0) begin
            chk("rx_start_seen", 32'd0, 32'd1);
            return;
        end
        start_cyc = cyc;
        for (int b = 0; b < nbits; b++) begin
            bits[b] = txd;
            for (int c = 0; c < div; c++) begin
                @(negedge clk);
                if (txd !== bits[b]) glitches++;
            end
            @(negedge clk);
        end
        end_cyc = cyc;
    endtask

    task automatic check_frame(input string tag, input int div, input int nbits,
                               input logic [15:0] exp_bits, input int exp_len,
                               output int start_cyc, output int end_cyc);
        logic [15:0] bits;
        int          glitches;
        rx_frame(div, nbits, bits, glitches, start_cyc, end_cyc);
        chk({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        chk({tag, "_stable"}, glitches, 0);
        chk({tag, "_len"}, end_cyc - start_cyc, exp_len);
        chk({tag, "_done"}, 32'(frame_done), 32'd1);
        chk({tag, "_idle_txd"}, 32'(txd), 32'd1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int s0, e0, s1, e1, rd0, bad_rd, low;

        srst = 1'b1;
        i_enable = 1'b1;
        i_clkdiv = 16'd3;
        i_parity_en = 1'b0;
        i_parity_odd = 1'b0;
        i_two_stop = 1'b0;
        push(8'h55);
        repeat (3) @(negedge clk);
        #1;
        // Reset held with data available: no pop, idle outputs.
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_no_pop", rd_cnt, 0);

        // 0x55, div=3, no parity, 1 stop: 40 cycles.
        @(negedge clk);
        srst = 1'b0;
        check_frame("f55", 3, 10, 16'h02AA, 40, s0, e0);
        chk("f55_pop_to_start", s0 - last_rd_cyc, 2);
        repeat (5) @(negedge clk);
        chk("f55_rd_cnt", rd_cnt, 1);
        chk("f55_done_cnt", fd_cnt, 1);

        // 0x07 even parity then odd parity, div=0: 11 cycles each.
        i_clkdiv = 16'd0;
        i_parity_en = 1'b1;
        i_parity_odd = 1'b0;
        push(8'h07);
        check_frame("f07e", 0, 11, 16'h060E, 11, s0, e0);
        repeat (2) @(negedge clk);
        i_parity_odd = 1'b1;
        push(8'h07);
        fork
            check_frame("f07o", 0, 11, 16'h040E, 11, s0, e0);
            begin
                // Changing config mid-frame must not disturb the latched settings.
                repeat (5) @(negedge clk);
                i_parity_odd = 1'b0;
                i_clkdiv = 16'd5;
                i_two_stop = 1'b1;
            end
        join
        repeat (2) @(negedge clk);

        // Three queued bytes, two stop bits, div=1: 22 cycles each, 2 idle cycles between.
        i_enable = 1'b0;
        i_clkdiv = 16'd1;
        i_parity_en = 1'b0;
        i_two_stop = 1'b1;
        push(8'hA1);
        push(8'h00);
        push(8'hFF);
        rd0 = rd_cnt;
        @(negedge clk);
        i_enable = 1'b1;
        check_frame("fA1", 1, 11, 16'h0742, 22, s0, e0);
        check_frame("f00", 1, 11, 16'h0600, 22, s1, e1);
        chk("f00_gap", s1 - e0, 2);
        check_frame("fFF", 1, 11, 16'h07FE, 22, s0, e0);
        chk("fFF_gap", s0 - e1, 2);
        repeat (3) @(negedge clk);
        chk("b2b_rd_cnt", rd_cnt - rd0, 3);

        // Enable dropped during DATA of the first of two bytes.
        i_enable = 1'b0;
        i_two_stop = 1'b0;
        push(8'h3C);
        push(8'hC3);
        rd0 = rd_cnt;
        @(negedge clk);
        i_enable = 1'b1;
        fork
            check_frame("f3C", 1, 10, 16'h0278, 20, s0, e0);
            begin
                repeat (6) @(negedge clk);
                i_enable = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        #1;
        chk("dis_rd_cnt", rd_cnt - rd0, 1);
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_txd", 32'(txd), 32'd1);

        // Reset in the middle of data bit 4 of 0xC3, then 0x5A goes out cleanly.
        @(negedge clk);
        i_clkdiv = 16'd3;
        push(8'h5A);
        rd0 = rd_cnt;
        i_enable = 1'b1;
        repeat (23) @(negedge clk);
        chk("mid_txd_bit4", 32'(txd), 32'd0);
        chk("mid_busy", 32'(busy), 32'd1);
        srst = 1'b1;
        @(negedge clk);
        chk("srst_txd", 32'(txd), 32'd1);
        chk("srst_busy", 32'(busy), 32'd0);
        srst = 1'b0;
        check_frame("f5A", 3, 10, 16'h02B4, 40, s0, e0);
        chk("f5A_pop_to_start", s0 - last_rd_cyc, 2);
        chk("srst_rd_cnt", rd_cnt - rd0, 2);

        // Empty FIFO with enable high: no pops, line idle.
        rd0 = rd_cnt;
        bad_rd = 0;
        low = 0;
        repeat (100) begin
            @(negedge clk);
            #1;
            if (rd_en !== 1'b0) bad_rd++;
            if (txd !== 1'b1) low++;
        end
        chk("empty_rd_en", bad_rd, 0);
        chk("empty_txd", low, 0);
        chk("empty_rd_cnt", rd_cnt - rd0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the byte FIFO behind the APB FIFO manager. It pops one entry at a time from a standard-read (non-FWFT) FIFO and emits it as an asynchronous UART frame: start bit, data LSB first, optional parity, then one or two stop bits. The block sits directly downstream of the TX FIFO's read port (`rd_en`/`dout`/`empty`). Its configuration inputs are driven from register fields.

## Interface
- `G_DATAWIDTH`, 8, data bits per frame; equals the FIFO width.
- `G_DIVWIDTH`, 16, width of the bit-period divisor.
- `clk`  in  1  single clock.
- `srst`  in  1  synchronous reset, active-high.
- `i_enable`  in  1  permits starting new frames.
- `i_clkdiv`  in  G_DIVWIDTH  bit period minus one, in clk cycles.
- `i_parity_en`  in  1  appends a parity bit.
- `i_parity_odd`  in  1  0 = even parity, 1 = odd parity.
- `i_two_stop`  in  1  0 = one stop bit, 1 = two stop bits.
- `i_fifo_empty`  in  1  FIFO empty flag.
- `o_fifo_rd_en`  out  1  FIFO read strobe, one cycle per frame.
- `i_fifo_dout`  in  G_DATAWIDTH  FIFO read data, valid one cycle after `o_fifo_rd_en`.
- `o_txd`  out  1  serial line; idles high.
- `o_busy`  out  1  high whenever state is not IDLE.
- `o_frame_done`  out  1  one-cycle pulse after each completed frame.

## Operation
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE:
  - `o_fifo_rd_en` = IDLE & `i_enable` & ~`i_fifo_empty` (combinational).
  - When it is high, go to FETCH.
- FETCH (1 cycle):
  - Capture `i_fifo_dout` into the shift register.
  - Latch `i_clkdiv`, `i_parity_en`, `i_parity_odd` and `i_two_stop` for the whole frame.
  - Go to START.
- Bit timer: each serial bit lasts latched clkdiv+1 cycles. clkdiv=0 gives 1 cycle per bit. Timer reloads at every bit boundary.
- START: `o_txd`=0 for one bit period, then go to DATA.
- DATA: shift out G_DATAWIDTH bits, LSB first.
  - Bit counter is $clog2(G_DATAWIDTH) bits wide.
  - After the last bit, go to PARITY if parity is enabled, otherwise go to STOP.
- PARITY: one bit period.
  - Even parity: `o_txd` = XOR of the data bits.
  - Odd parity: `o_txd` = inverted XOR of the data bits.
- STOP: `o_txd`=1 for one bit period (two if `i_two_stop`), then return to IDLE.
- `o_frame_done` is high for the first IDLE cycle after STOP.
- Deasserting `i_enable` mid-frame completes the current frame; no further pop occurs.
- Config changes mid-frame have no effect until the next FETCH.
- The block never asserts `o_fifo_rd_en` while `i_fifo_empty`=1, so it cannot cause FIFO underflow.
- Reset values: state=IDLE, `o_txd`=1, `o_busy`=0, `o_frame_done`=0, `o_fifo_rd_en`=0, counters=0.

## Timing
- `o_txd` is registered.
- Pop in cycle N → FETCH in N+1 → `o_txd` falls at N+2.
- Frame length: (1 + G_DATAWIDTH + P + S) × (clkdiv+1) cycles, where P = 1 if parity is enabled else 0, and S = 1 or 2 stop bits.
- Back-to-back frames: exactly 2 cycles of line-high (IDLE, FETCH) between the end of STOP and the next start bit.
- `srst` is seen at a rising edge. On the next cycle the block is in IDLE with `o_txd`=1, even mid-frame. The partial frame is abandoned and the popped byte is lost.
- `srst` and pop in the same cycle: reset wins.

## Structure
- Package `fifo_uart_pkg`:
  - state enum `uart_tx_state_e`;
  - parity-mode constants;
  - frame-bit-count helper function.
- Sub-module `uart_bit_timer`: loadable down-counter that asserts `o_tick` on the last cycle of each bit period, given the latched divisor.

## Test plan
- div=3, no parity, 1 stop, FIFO holds 0x55 → one `rd_en` pulse. `o_txd` = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total). `o_frame_done` pulses once.
- 0x07 with even parity, then 0x07 with odd parity, div=0 → parity bit = 1, then 0. Frame is 11 cycles (10 + parity bit).
- Three bytes 0xA1, 0x00, 0xFF queued, `i_two_stop`=1, div=1 → three `rd_en` pulses. Each frame is 22 cycles, with exactly 2 idle-high cycles between frames.
- `i_enable` dropped during DATA of byte 1 of 2 → byte 1 completes. No second `rd_en`. `o_busy`=0 afterwards.
- `srst` in the middle of the 5th data bit → next cycle `o_txd`=1, `o_busy`=0. With `i_enable` still high, a new frame starts from the next FIFO entry.
- FIFO empty with `i_enable`=1 for 100 cycles → `o_fifo_rd_en` never asserts and `o_txd` stays 1.
